// File: rtl/access_pkg.sv
// Shared types and widths for the access-code controller.
package access_pkg;

   localparam int DIGIT_W = 4;
   localparam int CODE_W  = 12;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      GRANT   = 3'd3,
      DENY    = 3'd4,
      LOCKOUT = 3'd5
   } acc_state_t;

endpackage

// File: rtl/access_controller_hold_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module hold_timer #(
   parameter int W = 8
) (
   input  logic         clk2,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/access_controller.sv
// Access-code entry sequencer: digit capture, table match,
// grant/deny/lockout indications and display-source select.
module access_controller
   import access_pkg::*;
#(
   parameter int NUM_CODES   = 4,
   parameter int ENTRY_TO    = 50,
   parameter int GRANT_HOLD  = 20,
   parameter int DENY_HOLD   = 20,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 200,
   localparam int AW = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1
) (
   input  logic               clk2,
   input  logic               reset,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               enter,
   input  logic               cancel,
   input  logic               prog_we,
   input  logic [AW-1:0]      prog_addr,
   input  logic [CODE_W-1:0]  prog_code,
   input  logic               prog_clr,
   output logic [CODE_W-1:0]  code_buf,
   output logic [1:0]         entry_count,
   output logic               select,
   output logic               grant,
   output logic               deny,
   output logic               lockout,
   output logic               busy
);

   localparam int T01  = (ENTRY_TO > GRANT_HOLD) ? ENTRY_TO : GRANT_HOLD;
   localparam int T23  = (DENY_HOLD > LOCK_CYCLES) ? DENY_HOLD : LOCK_CYCLES;
   localparam int TMAX = (T01 > T23) ? T01 : T23;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int FW   = $clog2(MAX_FAILS + 1);

   acc_state_t          state;
   logic [FW-1:0]       fail_cnt;
   logic [CODE_W-1:0]   tbl_code [NUM_CODES];
   logic [NUM_CODES-1:0] tbl_vld;
   logic                match;
   logic                at_max;
   logic                tmr_load;
   logic [TW-1:0]       tmr_val;
   logic                tmr_done;

   hold_timer #(.W(TW)) u_timer (
      .clk2     (clk2),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         tbl_vld <= '0;
         for (int i = 0; i < NUM_CODES; i++)
            tbl_code[i] <= '0;
      end else if (prog_clr) begin
         tbl_vld <= '0;
      end else if (prog_we) begin
         tbl_vld[prog_addr]  <= 1'b1;
         tbl_code[prog_addr] <= prog_code;
      end
   end

   // Table registers update at the edge, so CHECK sees the old contents.
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < NUM_CODES; i++)
         if (tbl_vld[i] && tbl_code[i] == code_buf)
            match = 1'b1;
      if (entry_count != 2'd3)
         match = 1'b0;
   end

   assign at_max = (fail_cnt == FW'(MAX_FAILS));

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state)
         IDLE: begin
            tmr_load = digit_valid;
            tmr_val  = TW'(ENTRY_TO - 1);
         end
         ENTRY: begin
            tmr_load = digit_valid && !enter && !cancel;
            tmr_val  = TW'(ENTRY_TO - 1);
         end
         CHECK: begin
            tmr_load = 1'b1;
            tmr_val  = match ? TW'(GRANT_HOLD - 1)
                             : TW'(DENY_HOLD - 1);
         end
         DENY: begin
            tmr_load = tmr_done && at_max;
            tmr_val  = TW'(LOCK_CYCLES - 1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         code_buf    <= '0;
         entry_count <= '0;
         select      <= 1'b1;
         grant       <= 1'b0;
         deny        <= 1'b0;
         lockout     <= 1'b0;
         busy        <= 1'b0;
         fail_cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (digit_valid) begin
                  state       <= ENTRY;
                  code_buf    <= {8'h0, digit};
                  entry_count <= 2'd1;
                  select      <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            ENTRY: begin
               if (cancel || (!enter && !digit_valid && tmr_done)) begin
                  state       <= IDLE;
                  code_buf    <= '0;
                  entry_count <= '0;
                  select      <= 1'b1;
                  busy        <= 1'b0;
               end else if (enter) begin
                  state <= CHECK;
               end else if (digit_valid && entry_count != 2'd3) begin
                  code_buf    <= {code_buf[7:0], digit};
                  entry_count <= entry_count + 2'd1;
               end
            end
            CHECK: begin
               if (match) begin
                  state    <= GRANT;
                  grant    <= 1'b1;
                  fail_cnt <= '0;
               end else begin
                  state    <= DENY;
                  deny     <= 1'b1;
                  fail_cnt <= fail_cnt + FW'(1);
               end
            end
            GRANT: begin
               if (tmr_done) begin
                  state       <= IDLE;
                  grant       <= 1'b0;
                  code_buf    <= '0;
                  entry_count <= '0;
                  select      <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            DENY: begin
               if (tmr_done) begin
                  deny   <= 1'b0;
                  select <= 1'b1;
                  if (at_max) begin
                     state   <= LOCKOUT;
                     lockout <= 1'b1;
                  end else begin
                     state       <= IDLE;
                     code_buf    <= '0;
                     entry_count <= '0;
                     busy        <= 1'b0;
                  end
               end
            end
            LOCKOUT: begin
               if (tmr_done) begin
                  state       <= IDLE;
                  lockout     <= 1'b0;
                  fail_cnt    <= '0;
                  code_buf    <= '0;
                  entry_count <= '0;
                  busy        <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
